neuron_layer_tdm: RTL and testbench

NEURON_LAYER_TDM -- requirements
Module: neuron_layer_tdm

---
 rtl/cnn1d_pkg.sv | 37 +++
 rtl/neuron_layer_tdm_if.sv | 45 ++++
 rtl/neuron_lane.sv | 52 +++++
 rtl/neuron_layer_tdm.sv | 125 ++++++++++++
 tb/tb_neuron_layer_tdm.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the TDM neuron layer: FSM state enum,
// constant clog2 and a signed saturation helper.
package cnn1d_pkg;

  // Widest accumulator the saturation helper accepts.
  localparam int SAT_W = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_DONE
  } state_t;

  function automatic int clog2(input int n);
    int r = 0;
    int v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Clamp v to the signed range of a w-bit word; the caller keeps the low w bits.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    min_v = -max_v - SAT_W'(1);
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/neuron_layer_tdm_if.sv
// Configuration port plus input/output valid-ready streams of the neuron layer.
interface neuron_layer_tdm_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_NEURONS   = 32,
  parameter int NEURON_INPUTS = 5
);
  import cnn1d_pkg::*;

  localparam int NW = (clog2(NUM_NEURONS) > 0) ? clog2(NUM_NEURONS) : 1;
  localparam int IW = (clog2(NEURON_INPUTS) > 0) ? clog2(NEURON_INPUTS) : 1;

  logic                                     cfg_wr_en;
  logic                                     cfg_wr_sel;
  logic [NW-1:0]                            cfg_wr_neuron;
  logic [IW-1:0]                            cfg_wr_input;
  logic [DATA_WIDTH-1:0]                    cfg_wr_data;
  logic                                     cfg_busy;

  logic                                     neuron_layer_ready_in;
  logic                                     neuron_layer_valid_in;
  logic [NEURON_INPUTS-1:0][DATA_WIDTH-1:0] neuron_layer_data_in;

  logic                                     neuron_layer_ready_out;
  logic                                     neuron_layer_valid_out;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]   neuron_layer_data_out;

  modport master (
    output cfg_wr_en, cfg_wr_sel, cfg_wr_neuron, cfg_wr_input, cfg_wr_data,
    input  cfg_busy,
    input  neuron_layer_ready_in,
    output neuron_layer_valid_in, neuron_layer_data_in,
    output neuron_layer_ready_out,
    input  neuron_layer_valid_out, neuron_layer_data_out
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_sel, cfg_wr_neuron, cfg_wr_input, cfg_wr_data,
    output cfg_busy,
    output neuron_layer_ready_in,
    input  neuron_layer_valid_in, neuron_layer_data_in,
    input  neuron_layer_ready_out,
    output neuron_layer_valid_out, neuron_layer_data_out
  );

endinterface

// File: rtl/neuron_lane.sv
// One MAC lane: full-precision accumulate, bias add, rescale and saturate.
// Optional ReLU clamp when NEURON_LAYER_RELU_EN is defined.
module neuron_lane
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FRACTION      = 24,
  parameter int NEURON_INPUTS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mac_en,
  input  logic                         bias_en,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic signed [DATA_WIDTH-1:0] weight,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam int ACC_W = 2 * DATA_WIDTH + clog2(NEURON_INPUTS + 1);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        acc_q;
  logic signed [ACC_W-1:0]        biased;
  logic signed [ACC_W-1:0]        shifted;
  logic signed [DATA_WIDTH-1:0]   sat_v;

  // NOTE: combinational logic uses blocking '=' and assigns every output first,
  // so no latch is inferred; state in always_ff uses non-blocking '<='.
  always_comb begin
    prod    = data * weight;
    biased  = acc_q + (ACC_W'(bias) <<< FRACTION);
    shifted = biased >>> FRACTION;
    sat_v   = DATA_WIDTH'(saturate(SAT_W'(shifted), DATA_WIDTH));
`ifdef NEURON_LAYER_RELU_EN
    result  = (sat_v < 0) ? '0 : sat_v;
`else
    result  = sat_v;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (bias_en) begin
      acc_q <= '0;
    end else if (mac_en) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/neuron_layer_tdm.sv
// Time-multiplexed fully-connected layer: NUM_LANES lanes sweep the neurons in groups.
// Define NEURON_LAYER_RELU_EN to clamp negative outputs to zero.
module neuron_layer_tdm
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FRACTION      = 24,
  parameter int NUM_NEURONS   = 32,
  parameter int NEURON_INPUTS = 5,
  parameter int NUM_LANES     = 8
) (
  input  logic               clk,
  input  logic               rst,
  neuron_layer_tdm_if.slave  bus
);

  localparam int NUM_GROUPS = NUM_NEURONS / NUM_LANES;
  localparam int NW = (clog2(NUM_NEURONS) > 0) ? clog2(NUM_NEURONS) : 1;
  localparam int KW = (clog2(NEURON_INPUTS) > 0) ? clog2(NEURON_INPUTS) : 1;
  localparam int GW = (clog2(NUM_GROUPS) > 0) ? clog2(NUM_GROUPS) : 1;

  state_t state_q, state_d;
  logic [GW-1:0] p_q;
  logic [KW-1:0] k_q;
  logic          k_last, p_last;

  logic [NEURON_INPUTS-1:0][DATA_WIDTH-1:0] data_q;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]   data_out_q;
  logic [DATA_WIDTH-1:0] weight_q [NUM_NEURONS][NEURON_INPUTS];
  logic [DATA_WIDTH-1:0] bias_q   [NUM_NEURONS];

  logic [NW-1:0]         lane_idx    [NUM_LANES];
  logic [DATA_WIDTH-1:0] lane_result [NUM_LANES];

  assign k_last = (k_q == KW'(NEURON_INPUTS - 1));
  assign p_last = (p_q == GW'(NUM_GROUPS - 1));

  assign bus.neuron_layer_ready_in  = (state_q == S_IDLE);
  assign bus.cfg_busy               = (state_q != S_IDLE);
  assign bus.neuron_layer_valid_out = (state_q == S_DONE);
  assign bus.neuron_layer_data_out  = data_out_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.neuron_layer_valid_in) state_d = S_MAC;
      S_MAC:   if (k_last) state_d = S_BIAS;
      S_BIAS:  state_d = p_last ? S_DONE : S_MAC;
      S_DONE:  if (bus.neuron_layer_ready_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_idx[l] = NW'(int'(p_q) * NUM_LANES + l);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      k_q        <= '0;
      data_q     <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.neuron_layer_valid_in) begin
            data_q <= bus.neuron_layer_data_in;
            p_q    <= '0;
            k_q    <= '0;
          end
        end
        S_MAC: if (!k_last) k_q <= k_q + 1'b1;
        S_BIAS: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            data_out_q[lane_idx[l]] <= lane_result[l];
          end
          k_q <= '0;
          if (!p_last) p_q <= p_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the coefficient arrays are cleared by reset on purpose, so a layer that
  // comes out of reset computes bias-free zeros instead of stale products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        bias_q[n] <= '0;
        for (int i = 0; i < NEURON_INPUTS; i++) weight_q[n][i] <= '0;
      end
    end else if (bus.cfg_wr_en && state_q == S_IDLE &&
                 int'(bus.cfg_wr_neuron) < NUM_NEURONS) begin
      if (bus.cfg_wr_sel) begin
        bias_q[bus.cfg_wr_neuron] <= bus.cfg_wr_data;
      end else if (int'(bus.cfg_wr_input) < NEURON_INPUTS) begin
        weight_q[bus.cfg_wr_neuron][bus.cfg_wr_input] <= bus.cfg_wr_data;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    neuron_lane #(
      .DATA_WIDTH    (DATA_WIDTH),
      .FRACTION      (FRACTION),
      .NEURON_INPUTS (NEURON_INPUTS)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .mac_en  (state_q == S_MAC),
      .bias_en (state_q == S_BIAS),
      .data    (data_q[k_q]),
      .weight  (weight_q[lane_idx[l]][k_q]),
      .bias    (bias_q[lane_idx[l]]),
      .result  (lane_result[l])
    );
  end

endmodule

// File: tb/tb_neuron_layer_tdm.sv
// Directed self-checking bench for neuron_layer_tdm (default parameters, Q8.24).
module tb_neuron_layer_tdm;

  localparam int DW = 32;
  localparam int NN = 32;
  localparam int NI = 5;
  localparam logic [31:0] ONE = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  neuron_layer_tdm_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN), .NEURON_INPUTS(NI)) bus ();

  neuron_layer_tdm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input bit sel, input int neuron, input int inp, input logic [31:0] d);
    bus.cfg_wr_en     = 1'b1;
    bus.cfg_wr_sel    = sel;
    bus.cfg_wr_neuron = 5'(neuron);
    bus.cfg_wr_input  = 3'(inp);
    bus.cfg_wr_data   = d;
    step();
    bus.cfg_wr_en     = 1'b0;
  endtask

  // Accept one vector with all inputs = din; lat counts edges from the accept edge to valid_out.
  task automatic run_txn(input logic [31:0] din, input bit ack, output int lat);
    for (int i = 0; i < NI; i++) bus.neuron_layer_data_in[i] = din;
    bus.neuron_layer_valid_in = 1'b1;
    step();
    lat = 1;
    bus.neuron_layer_valid_in = 1'b0;
    while (!bus.neuron_layer_valid_out && lat < 200) begin
      step();
      lat++;
    end
    if (ack) begin
      bus.neuron_layer_ready_out = 1'b1;
      step();
      bus.neuron_layer_ready_out = 1'b0;
    end
  endtask

  function automatic bit others_zero(input int keep_a, input int keep_b);
    bit z = 1'b1;
    for (int n = 0; n < NN; n++)
      if (n != keep_a && n != keep_b && bus.neuron_layer_data_out[n] !== 32'h0) z = 1'b0;
    return z;
  endfunction

  initial begin
    int lat;
    logic [NN*DW-1:0] snap;
    logic [31:0] neg_exp;

`ifdef NEURON_LAYER_RELU_EN
    neg_exp = 32'h0000_0000;
`else
    neg_exp = 32'h8000_0000;
`endif

    bus.cfg_wr_en = 1'b0;
    bus.cfg_wr_sel = 1'b0;
    bus.cfg_wr_neuron = '0;
    bus.cfg_wr_input = '0;
    bus.cfg_wr_data = '0;
    bus.neuron_layer_valid_in = 1'b0;
    bus.neuron_layer_data_in = '0;
    bus.neuron_layer_ready_out = 1'b0;

    // Reset held for three cycles
    rst = 1'b0;
    repeat (3) step();
    check("rst_valid_out", 64'(bus.neuron_layer_valid_out), 64'd0);
    check("rst_ready_in", 64'(bus.neuron_layer_ready_in), 64'd1);
    check("rst_cfg_busy", 64'(bus.cfg_busy), 64'd0);
    check("rst_dout_zero", 64'(bus.neuron_layer_data_out == '0), 64'd1);
    rst = 1'b1;
    step();

    // Basic: neuron 0 = 5 * 1.0 * 1.0 + 0.5; bias written with a junk input index
    for (int k = 0; k < NI; k++) cfg_write(1'b0, 0, k, ONE);
    cfg_write(1'b1, 0, 7, 32'h0080_0000);
    run_txn(ONE, 1'b1, lat);
    check("basic_latency", 64'(lat), 64'd25);
    check("basic_dout0", 64'(bus.neuron_layer_data_out[0]), 64'h0580_0000);
    check("basic_others_zero", 64'(others_zero(0, 0)), 64'd1);
    check("basic_idle_after_ack", 64'(bus.neuron_layer_ready_in), 64'd1);

    // Saturation: neuron 5 weights +100.0 then -100.0
    for (int k = 0; k < NI; k++) cfg_write(1'b0, 5, k, 32'h6400_0000);
    run_txn(ONE, 1'b1, lat);
    check("sat_pos_dout5", 64'(bus.neuron_layer_data_out[5]), 64'h7FFF_FFFF);
    check("sat_pos_dout0", 64'(bus.neuron_layer_data_out[0]), 64'h0580_0000);
    for (int k = 0; k < NI; k++) cfg_write(1'b0, 5, k, 32'h9C00_0000);
    run_txn(ONE, 1'b1, lat);
    check("sat_neg_dout5", 64'(bus.neuron_layer_data_out[5]), 64'(neg_exp));
    check("sat_neg_others_zero", 64'(others_zero(0, 5)), 64'd1);

    // Backpressure: sit in DONE for 10 cycles, try a cfg write and a new input
    run_txn(ONE, 1'b0, lat);
    snap = bus.neuron_layer_data_out;
    check("bp_busy", 64'(bus.cfg_busy), 64'd1);
    bus.neuron_layer_valid_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) cfg_write(1'b1, 0, 0, 32'h7F00_0000);
      else step();
      check("bp_valid_out", 64'(bus.neuron_layer_valid_out), 64'd1);
      check("bp_ready_in", 64'(bus.neuron_layer_ready_in), 64'd0);
      check("bp_dout_stable", 64'(bus.neuron_layer_data_out === snap), 64'd1);
    end
    bus.neuron_layer_ready_out = 1'b1;
    step();
    bus.neuron_layer_ready_out = 1'b0;
    check("bp_idle_next", 64'(bus.neuron_layer_ready_in), 64'd1);
    check("bp_valid_drop", 64'(bus.neuron_layer_valid_out), 64'd0);
    check("bp_held_result", 64'(bus.neuron_layer_data_out === snap), 64'd1);
    bus.neuron_layer_valid_in = 1'b0;
    run_txn(ONE, 1'b1, lat);
    check("bp_cfg_ignored", 64'(bus.neuron_layer_data_out[0]), 64'h0580_0000);

    // Reset in the middle of MAC
    for (int i = 0; i < NI; i++) bus.neuron_layer_data_in[i] = ONE;
    bus.neuron_layer_valid_in = 1'b1;
    step();
    bus.neuron_layer_valid_in = 1'b0;
    repeat (6) step();
    check("mid_busy_before", 64'(bus.cfg_busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_ready_in", 64'(bus.neuron_layer_ready_in), 64'd1);
    check("mid_valid_out", 64'(bus.neuron_layer_valid_out), 64'd0);
    check("mid_cfg_busy", 64'(bus.cfg_busy), 64'd0);
    check("mid_dout_zero", 64'(bus.neuron_layer_data_out == '0), 64'd1);
    step();
    rst = 1'b1;
    step();
    run_txn(ONE, 1'b1, lat);
    check("mid_latency", 64'(lat), 64'd25);
    check("mid_weights_zero", 64'(bus.neuron_layer_data_out == '0), 64'd1);

    // Lane mapping: neuron n weight (n+1)*1.0, inputs 0.125
    for (int n = 0; n < NN; n++)
      for (int k = 0; k < NI; k++) cfg_write(1'b0, n, k, 32'((n + 1) * ONE));
    run_txn(32'h0020_0000, 1'b1, lat);
    check("map_latency", 64'(lat), 64'd25);
    for (int n = 0; n < NN; n++)
      check($sformatf("map_dout%0d", n), 64'(bus.neuron_layer_data_out[n]),
            64'((n + 1) * 32'h00A0_0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
